// File: rtl/pwm_multi.sv
// Multi-channel PWM sharing one period counter, double-buffered settings.
// Optional build macro: PWM_MULTI_CENTER_EN (adds i_center, up/down count).
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_top/_valid          pending period top value
//   i_compare/_sel/_valid pending compare for one channel
//   i_invert, i_enable,
//   i_cfg_valid           pending polarity/enable (and i_center if built)
//   o_pwm                 registered channel outputs (lag o_counter by 1)
//   o_counter             current count
//   o_period_start        high while o_counter == 0
module pwm_multi #(
  parameter int RESOLUTION = 8,
  parameter int CHANNELS   = 4,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [RESOLUTION-1:0] i_top,
  input  logic                  i_top_valid,
  input  logic [RESOLUTION:0]   i_compare,
  input  logic [SEL_W-1:0]      i_compare_sel,
  input  logic                  i_compare_valid,
  input  logic [CHANNELS-1:0]   i_invert,
  input  logic [CHANNELS-1:0]   i_enable,
  input  logic                  i_cfg_valid,
`ifdef PWM_MULTI_CENTER_EN
  input  logic                  i_center,
`endif
  output logic [CHANNELS-1:0]   o_pwm,
  output logic [RESOLUTION-1:0] o_counter,
  output logic                  o_period_start
);

  localparam logic [RESOLUTION-1:0] ONE = RESOLUTION'(1);

  logic [RESOLUTION-1:0] cnt_q, cnt_d;
  logic [RESOLUTION-1:0] top_q, top_p_q;
  logic [CHANNELS-1:0][RESOLUTION:0] cmp_q, cmp_p_q;
  logic [CHANNELS-1:0] inv_q, inv_p_q;
  logic [CHANNELS-1:0] en_q, en_p_q;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic boundary;
`ifdef PWM_MULTI_CENTER_EN
  logic ctr_q, ctr_p_q;
  logic dir_q, dir_d;
`endif

  always_comb begin
    cnt_d    = cnt_q + ONE;
    boundary = (cnt_q == top_q);
`ifdef PWM_MULTI_CENTER_EN
    dir_d = dir_q;
    if (ctr_q) begin
      // Period ends on the 1->0 step going down; with top==1 the
      // peak at 1 is also the last count before 0.
      boundary = (top_q == '0) ||
                 ((cnt_q == ONE) && (dir_q || (top_q == ONE)));
      if (dir_q || (cnt_q == top_q)) begin
        cnt_d = cnt_q - ONE;
        dir_d = 1'b1;
      end
    end
    if (boundary) dir_d = 1'b0;
`endif
    if (boundary) cnt_d = '0;
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en_q[i]
        ? (({1'b0, cnt_q} < cmp_q[i]) ^ inv_q[i])
        : inv_q[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      top_q   <= '0;
      top_p_q <= '0;
      cmp_q   <= '0;
      cmp_p_q <= '0;
      inv_q   <= '0;
      inv_p_q <= '0;
      en_q    <= '0;
      en_p_q  <= '0;
      pwm_q   <= '0;
`ifdef PWM_MULTI_CENTER_EN
      ctr_q   <= 1'b0;
      ctr_p_q <= 1'b0;
      dir_q   <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
`ifdef PWM_MULTI_CENTER_EN
      dir_q <= dir_d;
`endif
      if (i_top_valid) top_p_q <= i_top;
      for (int i = 0; i < CHANNELS; i++) begin
        if (i_compare_valid && (i_compare_sel == SEL_W'(i)))
          cmp_p_q[i] <= i_compare;
      end
      if (i_cfg_valid) begin
        inv_p_q <= i_invert;
        en_p_q  <= i_enable;
`ifdef PWM_MULTI_CENTER_EN
        ctr_p_q <= i_center;
`endif
      end
      if (boundary) begin
        top_q <= top_p_q;
        cmp_q <= cmp_p_q;
        inv_q <= inv_p_q;
        en_q  <= en_p_q;
`ifdef PWM_MULTI_CENTER_EN
        ctr_q <= ctr_p_q;
`endif
      end
    end
  end

  assign o_pwm     = pwm_q;
  assign o_counter = cnt_q;
  // Gated by reset so the flag reads low while reset is held.
  assign o_period_start = i_rst_n && (cnt_q == '0);

endmodule
